// File: rtl/imm_decode_queue.sv
// RV32I immediate decoder feeding a DEPTH-entry FIFO between fetch and execute.
// Define IMM_DECODE_ZICSR_EN to decode SYSTEM-opcode CSR immediates.
module imm_decode_queue #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [DW-1:0] out_imm,
  output logic [2:0]    out_fmt,
  output logic          out_illegal
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [31:0]   instr;
    logic [DW-1:0] imm;
    logic [2:0]    fmt;
    logic          illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  entry_t      dec_entry;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // imm32 is built as a 32-bit signed value, then sign-extended to DW
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0010011: begin
        dec_fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32   = {27'b0, in_instr[24:20]};
          dec_ill = in_instr[25] ||
                    !(in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000);
        end else begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_ill = 1'b0;
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
`ifdef IMM_DECODE_ZICSR_EN
      7'b1110011: begin
        case (funct3)
          3'b101, 3'b110, 3'b111: begin
            dec_fmt = FMT_Z;
            dec_ill = 1'b0;
            imm32   = {27'b0, in_instr[19:15]};
          end
          3'b001, 3'b010, 3'b011: begin
            dec_fmt = FMT_I;
            dec_ill = 1'b0;
            imm32   = {20'b0, in_instr[31:20]};
          end
          default: begin
            dec_fmt = FMT_ILL;
            dec_ill = 1'b1;
          end
        endcase
      end
`endif
      default: begin
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_entry.instr   = in_instr;
  assign dec_entry.imm     = DW'($signed(imm32));
  assign dec_entry.fmt     = dec_fmt;
  assign dec_entry.illegal = dec_ill;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            in_ready_q, out_valid_q;
  logic            push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // flush wins over any push/pop in the same cycle
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      if (push && !pop)      count_nxt = count + CW'(1);
      else if (pop && !push) count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      in_ready_q  <= (count_nxt != CW'(DEPTH));
      out_valid_q <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec_entry;
  end

  entry_t head;
  assign head        = mem[rd_ptr];
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_valid_q ? head.instr   : '0;
  assign out_imm     = out_valid_q ? head.imm     : '0;
  assign out_fmt     = out_valid_q ? head.fmt     : '0;
  assign out_illegal = out_valid_q ? head.illegal : 1'b0;

endmodule

// File: doc/imm_decode_queue.md
Name: imm_decode_queue

Overview:
Pipelined, parametrised immediate generator for the RV32I front end, replacing the single-cycle combinational extender. It accepts raw instructions over a valid/ready handshake and decodes every base immediate format (I, S, B, U, J, plus shift-amount) from the instruction's own opcode field. Results are sign-extended to DW and buffered in a DEPTH-entry FIFO between fetch and execute. A synchronous flush supports branch redirect.

Parameters:
DW, 32, datapath/immediate width; legal values ≥ 32; immediate sign-extended to DW.
DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous queue clear
in_valid  in  1  instruction valid
in_ready  out  1  queue can accept (registered)
in_instr  in  32  raw instruction
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_instr  out  32  instruction of head entry
out_imm  out  DW  decoded immediate
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=Z(CSR) 7=illegal
out_illegal  out  1  unsupported opcode or bad shift encoding

Behaviour:
- Reset (rst_n low, asynchronous): count=0, wr_ptr=rd_ptr=0, out_valid=0, in_ready=1. Data outputs read 0.
- Decode is combinational on in_instr; the entry written holds instr, imm, fmt, illegal. Opcode is in_instr[6:0].
- Format mapping:
  - 0000011, 1100111 → I: imm = sext(i[31:20]).
  - 0010011, funct3 not 001/101 → I: imm = sext(i[31:20]).
  - 0010011, funct3 001/101 → I, shift: imm = zext(i[24:20]). Illegal if i[25]=1, or i[31:26] is not 000000 or 010000.
  - 0100011 → S: imm = sext({i[31:25], i[11:7]}).
  - 1100011 → B: imm = sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - 0110111, 0010111 → U: imm = {i[31:12], 12'b0}, sign-extended to DW.
  - 1101111 → J: imm = sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - 0110011 → R: imm = 0.
  - Anything else → fmt=7, illegal=1, imm=0.
- Handshakes:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH), taken from registered count only. No combinational path from out_ready to in_ready.
  - When full with a simultaneous pop, the push is not accepted that cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N if the queue was empty. Order is strictly FIFO.
- Head outputs: out_* come from storage at rd_ptr. When out_valid=0 they are forced to 0.
- Pointers: log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- flush: at the next edge count=0 and pointers=0. Flush overrides any push or pop in the same cycle; that push is discarded.
- Reset mid-operation: all entries are lost immediately; behaviour is identical to power-on reset.

Optional Feature:
Macro IMM_DECODE_ZICSR_EN.
- Defined: opcode 1110011 with funct3 101/110/111 → fmt=6, imm = zext(i[19:15]) (CSR zimm), illegal=0. Funct3 001/010/011 → fmt=1, imm = zext(i[31:20]) (CSR address).
- Not defined: opcode 1110011 → fmt=7, illegal=1, imm=0.

Test Plan:
1. Hold rst_n=0 → out_valid=0, in_ready=1, out_imm=0. Release, idle 3 cycles → unchanged.
2. Push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1. Push 0xFE112E23 (sw) → out_imm=0xFFFFFFFC, fmt=2.
3. Back-to-back pushes of 0x123450B7 (lui) then 0x001000EF (jal x1,+2048) → out_imm=0x12345000 fmt=4, then 0x00000800 fmt=5, in order.
4. Backpressure with out_ready=0 and DEPTH=2: push 3 instructions → in_ready=0 after 2 accepts, third held by source. Raise out_ready → all 3 emerge in order, no loss or duplication.
5. Fill 2 entries, then assert flush with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, the flush-cycle instruction is absent.
6. Push 0x0000007F → fmt=7, illegal=1, imm=0. Push 0x02009093 (slli with i[25]=1) → illegal=1. With IMM_DECODE_ZICSR_EN, push 0x3400D073 (csrrwi) → fmt=6, imm=0x1.
